// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/WB/HALT command sequencer around an external ALU.
// Ports: cmd_* handshake in, opcode/in_a/in_b to ALU, alu_out/a_is_zero back, acc/res_*/halted out.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic [2:0]       opcode,
  output logic [WIDTH-1:0] in_a,
  output logic [WIDTH-1:0] in_b,
  input  logic             a_is_zero,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] acc,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             halted
);

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  op_e              op_q, op_d;
  logic             skip_q, skip_d;

  logic             busy;
  logic             wr_acc;
  logic             is_sto;

  assign wr_acc = (op_q == OP_ADD) || (op_q == OP_AND) ||
                  (op_q == OP_XOR) || (op_q == OP_LDA);
  assign is_sto = (op_q == OP_STO);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    data_d  = data_q;
    skip_d  = skip_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // A pending skip swallows this command outright.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            op_d    = op_e'(cmd_op);
            data_d  = cmd_data;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        state_d = S_IDLE;
        if (wr_acc)
          acc_d = alu_out;
        if (op_q == OP_SKZ)
          skip_d = a_is_zero;
        if (op_q == OP_HLT)
          state_d = S_HALT;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      op_q    <= OP_HLT;
      data_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      data_q  <= data_d;
      skip_q  <= skip_d;
    end
  end

  // Moore decode straight off the state register.
  assign busy      = (state_q == S_EXEC) || (state_q == S_WB);
  assign cmd_ready = (state_q == S_IDLE);
  assign halted    = (state_q == S_HALT);
  assign opcode    = busy ? op_q : 3'd0;
  assign in_b      = busy ? data_q : '0;
  assign in_a      = acc_q;
  assign acc       = acc_q;
  assign res_valid = (state_q == S_WB) && (wr_acc || is_sto);

  always_comb begin
    res_data = '0;
    if (res_valid)
      res_data = is_sto ? acc_q : alu_out;
  end

endmodule
